// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared imuldiv request encodings: upstream fn codes, dispatch FSM states,
// and the {is_rem, is_signed} function field sent to the divider.
package imuldiv_muldiv_dispatch_pkg;

  typedef enum logic [2:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } fn_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    DIVFN_DIVU = 2'b00,
    DIVFN_DIV  = 2'b01,
    DIVFN_REMU = 2'b10,
    DIVFN_REM  = 2'b11
  } divfn_e;

  // Codes 5-7 are unsupported and never reach a sub-unit.
  function automatic logic fn_legal(input logic [2:0] fn);
    return fn <= FN_REMU;
  endfunction

  function automatic logic [1:0] div_fn(input logic [2:0] fn);
    case (fn)
      FN_DIV:  return DIVFN_DIV;
      FN_REM:  return DIVFN_REM;
      FN_REMU: return DIVFN_REMU;
      default: return DIVFN_DIVU;
    endcase
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_ctrl.sv
// Dispatch control FSM: accepts one request, issues it to the selected unit,
// waits for its response, then presents the result downstream.
module imuldiv_muldiv_dispatch_ctrl
  import imuldiv_muldiv_dispatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic muldivreq_val,
  input  logic req_legal,
  input  logic sel_mul,
  input  logic mulreq_rdy,
  input  logic mulresp_val,
  input  logic divreq_rdy,
  input  logic divresp_val,
  input  logic muldivresp_rdy,
  output logic muldivreq_rdy,
  output logic mulreq_val,
  output logic divreq_val,
  output logic mulresp_rdy,
  output logic divresp_rdy,
  output logic muldivresp_val,
  output logic req_en,
  output logic res_en,
  output logic res_illegal
);

  state_e state;
  state_e state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Every val/rdy output is a pure decode of state (reset only masks rdy).
  always_comb begin
    state_next     = state;
    muldivreq_rdy  = 1'b0;
    mulreq_val     = 1'b0;
    divreq_val     = 1'b0;
    mulresp_rdy    = 1'b0;
    divresp_rdy    = 1'b0;
    muldivresp_val = 1'b0;
    req_en         = 1'b0;
    res_en         = 1'b0;
    res_illegal    = 1'b0;
    case (state)
      ST_IDLE: begin
        muldivreq_rdy = !reset;
        if (muldivreq_val && !reset) begin
          req_en = 1'b1;
          if (req_legal) begin
            state_next = ST_ISSUE;
          end else begin
            res_en      = 1'b1;
            res_illegal = 1'b1;
            state_next  = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        mulreq_val = sel_mul;
        divreq_val = !sel_mul;
        if (sel_mul ? mulreq_rdy : divreq_rdy) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        mulresp_rdy = sel_mul;
        divresp_rdy = !sel_mul;
        if (sel_mul ? mulresp_val : divresp_val) begin
          res_en     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        muldivresp_val = 1'b1;
        if (muldivresp_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/imuldiv_muldiv_dispatch_dpath.sv
// Dispatch datapath: latched request fields, operand fan-out to the mul and
// div units, and the registered response result.
module imuldiv_muldiv_dispatch_dpath
  import imuldiv_muldiv_dispatch_pkg::*;
#(
  parameter logic [63:0] p_illegal_result = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_en,
  input  logic        res_en,
  input  logic        res_illegal,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic [63:0] mulresp_msg_result,
  input  logic [63:0] divresp_msg_result,
  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic [1:0]  divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic [63:0] muldivresp_msg_result,
  output logic        req_legal,
  output logic        sel_mul
);

  logic [2:0]  fn_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [63:0] result_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fn_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      if (req_en) begin
        fn_reg <= muldivreq_msg_fn;
        a_reg  <= muldivreq_msg_a;
        b_reg  <= muldivreq_msg_b;
      end
      if (res_en) begin
        if (res_illegal)
          result_reg <= p_illegal_result;
        else if (sel_mul)
          result_reg <= mulresp_msg_result;
        else
          result_reg <= divresp_msg_result;
      end
    end
  end

  assign req_legal             = fn_legal(muldivreq_msg_fn);
  assign sel_mul               = (fn_reg == FN_MUL);
  assign mulreq_msg_a          = a_reg;
  assign mulreq_msg_b          = b_reg;
  assign divreq_msg_a          = a_reg;
  assign divreq_msg_b          = b_reg;
  assign divreq_msg_fn         = div_fn(fn_reg);
  assign muldivresp_msg_result = result_reg;

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div dispatcher: routes one upstream request at a time to the iterative
// multiplier or divider and returns its 64-bit result downstream.
module imuldiv_muldiv_dispatch
  import imuldiv_muldiv_dispatch_pkg::*;
#(
  parameter logic [63:0] p_illegal_result = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,
  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,
  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,
  output logic [1:0]  divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy,
  output logic [63:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy
);

  logic req_en;
  logic res_en;
  logic res_illegal;
  logic req_legal;
  logic sel_mul;

  imuldiv_muldiv_dispatch_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .muldivreq_val  (muldivreq_val),
    .req_legal      (req_legal),
    .sel_mul        (sel_mul),
    .mulreq_rdy     (mulreq_rdy),
    .mulresp_val    (mulresp_val),
    .divreq_rdy     (divreq_rdy),
    .divresp_val    (divresp_val),
    .muldivresp_rdy (muldivresp_rdy),
    .muldivreq_rdy  (muldivreq_rdy),
    .mulreq_val     (mulreq_val),
    .divreq_val     (divreq_val),
    .mulresp_rdy    (mulresp_rdy),
    .divresp_rdy    (divresp_rdy),
    .muldivresp_val (muldivresp_val),
    .req_en         (req_en),
    .res_en         (res_en),
    .res_illegal    (res_illegal)
  );

  imuldiv_muldiv_dispatch_dpath #(
    .p_illegal_result (p_illegal_result)
  ) u_dpath (
    .clk                   (clk),
    .reset                 (reset),
    .req_en                (req_en),
    .res_en                (res_en),
    .res_illegal           (res_illegal),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .mulresp_msg_result    (mulresp_msg_result),
    .divresp_msg_result    (divresp_msg_result),
    .mulreq_msg_a          (mulreq_msg_a),
    .mulreq_msg_b          (mulreq_msg_b),
    .divreq_msg_fn         (divreq_msg_fn),
    .divreq_msg_a          (divreq_msg_a),
    .divreq_msg_b          (divreq_msg_b),
    .muldivresp_msg_result (muldivresp_msg_result),
    .req_legal             (req_legal),
    .sel_mul               (sel_mul)
  );

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
IMULDIV_MULDIV_DISPATCH -- requirements
Module: imuldiv_muldiv_dispatch

Interface
REQ-001 SHALL have parameter: p_illegal_result, 64'h0, result returned for unsupported fn codes.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on posedge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: muldivreq_msg_fn  in  3; muldivreq_msg_a  in  32; muldivreq_msg_b  in  32; muldivreq_val  in  1; muldivreq_rdy  out  1. These carry the upstream request.
REQ-005 SHALL have ports: mulreq_msg_a  out  32; mulreq_msg_b  out  32; mulreq_val  out  1; mulreq_rdy  in  1. These form the request side to the iterative mul unit.
REQ-006 SHALL have ports: mulresp_msg_result  in  64; mulresp_val  in  1; mulresp_rdy  out  1. These form the response side from the mul unit.
REQ-007 SHALL have ports: divreq_msg_fn  out  2 (quot/rem, signed/unsigned); divreq_msg_a  out  32; divreq_msg_b  out  32; divreq_val  out  1; divreq_rdy  in  1. These form the request side to the div unit.
REQ-008 SHALL have ports: divresp_msg_result  in  64 ({rem, quot}); divresp_val  in  1; divresp_rdy  out  1.
REQ-009 SHALL have ports: muldivresp_msg_result  out  64; muldivresp_val  out  1; muldivresp_rdy  in  1. These carry the downstream response.

Function
REQ-010 fn encoding SHALL be: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 illegal.
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-012 muldivreq_rdy SHALL be 1 only in IDLE; a request fires on val&&rdy.
REQ-013 On fire, the block SHALL latch fn/a/b and go to ISSUE if fn is legal, else load p_illegal_result and go to RESP.
REQ-014 ISSUE SHALL assert exactly one of mulreq_val or divreq_val (MUL goes to mul, fn 1-4 go to div) with the latched operands, hold them stable, and move to WAIT on the cycle the selected rdy is high.
REQ-015 divreq_msg_fn SHALL be {is_rem, is_signed}: DIV=2'b01, DIVU=2'b00, REM=2'b11, REMU=2'b10.
REQ-016 WAIT SHALL assert only the selected unit's resp_rdy; on its resp_val the block SHALL capture the 64-bit result unmodified and go to RESP.
REQ-017 RESP SHALL assert muldivresp_val with the registered result held stable; on muldivresp_rdy the FSM SHALL go to IDLE.
REQ-018 The block SHALL allow only one outstanding transaction; responses return in request order.
REQ-019 Minimum latency SHALL be: fire at cycle T, ISSUE at T+1, WAIT at T+2, capture at T+2 if resp_val, muldivresp_val at T+3. Illegal fn: muldivresp_val at T+1.
REQ-020 A response handshake in RESP and a new request SHALL NOT both complete in the same cycle; the next request can fire at earliest the cycle after IDLE is re-entered.
REQ-021 Stray resp_val from the unselected unit SHALL be ignored, and its resp_rdy SHALL stay 0.
REQ-022 All handshake outputs SHALL be registered-state decodes with no combinational path from any input val/rdy to an output val/rdy.

Reset
REQ-023 On reset the FSM SHALL go to IDLE, set all *_val and *_rdy outputs to 0 except muldivreq_rdy (1 after reset deasserts), and clear the result register to 0.
REQ-024 Reset in any state SHALL abandon the transaction, and no response SHALL be emitted for it.

Structure
REQ-025 The fn codes, FSM state encodings and divreq_msg_fn encoding SHALL live in a shared imuldiv package/include (imuldiv-MulDivReqMsg).
REQ-026 The block SHALL be split into dpath (operand/fn/result registers, muxes) and ctrl (FSM) sub-modules, imuldiv_muldiv_dispatch_dpath and imuldiv_muldiv_dispatch_ctrl.

Verification
REQ-027 The bench SHALL cover: MUL a=32'hFFFF_FFFD, b=7, mock mul returns 64'hFFFF_FFFF_FFFF_FFEB after 33 cycles -> muldivresp_result=64'hFFFF_FFFF_FFFF_FFEB, divreq_val never 1.
REQ-028 The bench SHALL cover: REM a=-7, b=2 -> divreq_msg_fn=2'b11, operands passed unchanged; mock div result {32'hFFFF_FFFF, 32'hFFFF_FFFD} returned verbatim.
REQ-029 The bench SHALL cover: fn=6 -> no sub-unit val, muldivresp_val at T+1, result 64'h0.
REQ-030 The bench SHALL cover: mulreq_rdy low 5 cycles, then muldivresp_rdy low 4 cycles -> mulreq_val and operands held, then result held stable, muldivreq_rdy=0 throughout.
REQ-031 The bench SHALL cover: reset asserted in WAIT -> next cycle IDLE, all vals 0; a following MUL 3x4 returns 64'd12.
REQ-032 The bench SHALL cover: back-to-back DIVU 100/7 then MUL 6x7 -> results {32'd2, 32'd14} then 64'd42, in order.
